// File: rtl/fft_pair_buffer_pkg.sv
// fft_pair_buffer_pkg: shared sample/coefficient types and constants for the FFT input stage
package fft_pair_buffer_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int COEFF_WIDTH = 16;
    localparam int R           = 14;
    localparam int FFT_N_MAX   = 1024;
    localparam logic signed [DATA_WIDTH-1:0] FIXED_POINT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] FIXED_POINT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] r;
        logic signed [DATA_WIDTH-1:0] i;
    } complex_product_t;

    typedef enum logic {FILL, PAIR} pair_state_t;

    // round half away from zero, used when building coefficient tables
    function automatic int round_coef(input real x);
        return $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
    endfunction
endpackage

// File: rtl/fft_twiddle_rom.sv
// fft_twiddle_rom: elaboration-built exp(-j2*pi*k/N) table with a registered read port
module fft_twiddle_rom
    import fft_pair_buffer_pkg::*;
#(
    parameter int N      = 64,
    parameter int ADDR_W = $clog2(N/2)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          rd_en,
    output logic signed [COEFF_WIDTH-1:0] w_r,
    output logic signed [COEFF_WIDTH-1:0] w_i
);
    logic signed [COEFF_WIDTH-1:0] tab_r [N/2];
    logic signed [COEFF_WIDTH-1:0] tab_i [N/2];

    if (COEFF_WIDTH < R + 2) begin : g_width_chk
        $error("COEFF_WIDTH must hold 2^R (COEFF_WIDTH >= R+2)");
    end

    for (genvar k = 0; k < N/2; k++) begin : g_tab
        localparam real ANG = 2.0 * 3.141592653589793 * k / N;
        localparam int  WR  = round_coef($cos(ANG) * (1 << R));
        localparam int  WI  = round_coef(-$sin(ANG) * (1 << R));
        assign tab_r[k] = COEFF_WIDTH'(WR);
        assign tab_i[k] = COEFF_WIDTH'(WI);
    end

    // registered lookup so the coefficient lines up with the registered sample pair
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_r <= '0;
            w_i <= '0;
        end else if (rd_en) begin
            w_r <= tab_r[addr];
            w_i <= tab_i[addr];
        end
    end
endmodule

// File: rtl/fft_pair_buffer.sv
// fft_pair_buffer: buffers the first half-frame and emits (x[k], x[k+N/2], W^k) pairs
module fft_pair_buffer
    import fft_pair_buffer_pkg::*;
#(
    parameter int N      = 64,
    parameter int ADDR_W = $clog2(N/2)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  complex_product_t              in_sample,
    output complex_product_t              A,
    output complex_product_t              B,
    output logic signed [COEFF_WIDTH-1:0] W_R,
    output logic signed [COEFF_WIDTH-1:0] W_I,
    output logic                          out_valid,
    output logic                          frame_done,
    output logic                          sof_err
);
    localparam logic [ADDR_W:0] FILL_LAST = (ADDR_W+1)'(N/2 - 1);
    localparam logic [ADDR_W:0] PAIR_LAST = (ADDR_W+1)'(N - 1);

    if (N < 4 || N > FFT_N_MAX || (N & (N - 1)) != 0) begin : g_n_chk
        $error("N must be a power of 2 in 4..FFT_N_MAX");
    end

    pair_state_t      state, state_nx;
    logic [ADDR_W:0]  cnt, cnt_nx;
    logic             wr_en, pair_en, last;
    logic [ADDR_W-1:0] idx;
    complex_product_t mem [N/2];

    assign idx = cnt[ADDR_W-1:0];

    // frame position and fill/pair phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // next-state: sof restarts the frame at index 0, otherwise step through fill then pair
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wr_en    = 1'b0;
        pair_en  = 1'b0;
        last     = 1'b0;
        if (in_valid) begin
            if (in_sof) begin
                state_nx = FILL;
                cnt_nx   = (ADDR_W+1)'(1);
                wr_en    = 1'b1;
            end else if (state == FILL) begin
                wr_en    = 1'b1;
                cnt_nx   = cnt + (ADDR_W+1)'(1);
                state_nx = (cnt == FILL_LAST) ? PAIR : FILL;
            end else begin
                pair_en  = 1'b1;
                last     = (cnt == PAIR_LAST);
                cnt_nx   = last ? '0 : cnt + (ADDR_W+1)'(1);
                state_nx = last ? FILL : PAIR;
            end
        end
    end

    // first-half delay buffer; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[in_sof ? '0 : idx] <= in_sample;
    end

    // register the pair and status flags; A/B hold between pairs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            A          <= '0;
            B          <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            out_valid  <= pair_en;
            frame_done <= last;
            if (pair_en) begin
                A <= mem[idx];
                B <= in_sample;
            end
            if (in_valid && in_sof && cnt != '0) sof_err <= 1'b1;
        end
    end

    fft_twiddle_rom #(.N(N), .ADDR_W(ADDR_W)) u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (idx),
        .rd_en   (pair_en),
        .w_r     (W_R),
        .w_i     (W_I)
    );
endmodule

// File: tb/tb_fft_pair_buffer.sv
// tb_fft_pair_buffer: scoreboard bench for the FFT pair buffer at N=8
module tb_fft_pair_buffer;
    import fft_pair_buffer_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
    complex_product_t in_sample = '0;
    complex_product_t A, B;
    logic signed [COEFF_WIDTH-1:0] W_R, W_I;
    logic out_valid, frame_done, sof_err;

    typedef struct {
        complex_product_t a;
        complex_product_t b;
        int wr;
        int wi;
        logic fd;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int total = 0, bad = 0, cyc = 0;
    int wr_tab[4] = '{16384, 11585, 0, -11585};
    int wi_tab[4] = '{0, -11585, -16384, -11585};

    fft_pair_buffer #(.N(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_sample  (in_sample),
        .A          (A),
        .B          (B),
        .W_R        (W_R),
        .W_I        (W_I),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic complex_product_t smp(input int base, input int k, input bit ext);
        complex_product_t s;
        if (ext) begin
            s.r = (k < 4) ? FIXED_POINT_MAX : FIXED_POINT_MIN;
            s.i = (k < 4) ? FIXED_POINT_MIN : FIXED_POINT_MAX;
        end else begin
            s.r = DATA_WIDTH'(base + k);
            s.i = DATA_WIDTH'(-(base + k));
        end
        return s;
    endfunction

    task automatic drive(input complex_product_t s, input logic sof, input bit exp_pair, input exp_t e);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_sof    = sof;
        in_sample = s;
        if (exp_pair) begin
            e.cyc = cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic frame(input int base, input bit gaps, input bit ext, input int from, input int to);
        for (int k = from; k < to; k++) begin
            exp_t e;
            e.a = '0; e.b = '0; e.wr = 0; e.wi = 0; e.fd = 1'b0; e.cyc = 0;
            if (k >= 4) begin
                e.a  = smp(base, k - 4, ext);
                e.b  = smp(base, k, ext);
                e.wr = wr_tab[k-4];
                e.wi = wi_tab[k-4];
                e.fd = (k == 7);
            end
            drive(smp(base, k, ext), k == 0, k >= 4, e);
            if (gaps) idle();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_A"}, A, 0);
        chk({tag, "_B"}, B, 0);
        chk({tag, "_W_R"}, W_R, 0);
        chk({tag, "_W_I"}, W_I, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_sof_err"}, sof_err, 0);
    endtask

    // monitor: every presented pair must match the oldest expectation on its exact cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_pair: no out_valid at cycle %0d, want A.r=%0d", q[0].cyc, q[0].a.r);
            void'(q.pop_front());
        end
        if (out_valid) begin
            if (q.size() == 0 || q[0].cyc != cyc) begin
                total++;
                bad++;
                $display("FAIL unexpected_pair: out_valid=1 at cycle %0d, want 0", cyc);
            end else begin
                me = q.pop_front();
                chk("A", A, me.a);
                chk("B", B, me.b);
                chk("W_R", int'(W_R), me.wr);
                chk("W_I", int'(W_I), me.wi);
                chk("frame_done", frame_done, me.fd);
            end
        end else begin
            chk("idle_frame_done", frame_done, 0);
        end
    end

    initial begin
        exp_t e0;
        e0.a = '0; e0.b = '0; e0.wr = 0; e0.wi = 0; e0.fd = 1'b0; e0.cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;
        // 1: single back-to-back frame
        frame(1, 1'b0, 1'b0, 0, 8);
        idle();
        // 2: same frame with a gap after every sample
        frame(1, 1'b1, 1'b0, 0, 8);
        idle();
        // 3: two frames with no gap between them
        frame(20, 1'b0, 1'b0, 0, 8);
        frame(40, 1'b0, 1'b0, 0, 8);
        idle();
        chk("sof_err_clean", sof_err, 0);
        // 4: sof on the third sample restarts the frame
        drive(smp(60, 0, 1'b0), 1'b1, 1'b0, e0);
        drive(smp(60, 1, 1'b0), 1'b0, 1'b0, e0);
        frame(70, 1'b0, 1'b0, 0, 1);
        idle();
        @(negedge clk);
        chk("sof_err_set", sof_err, 1);
        frame(70, 1'b0, 1'b0, 1, 8);
        idle();
        chk("sof_err_sticky", sof_err, 1);
        // 5: asynchronous reset after two pairs
        frame(80, 1'b0, 1'b0, 0, 6);
        idle();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        chk("reset_q_empty", q.size(), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        frame(90, 1'b0, 1'b0, 0, 8);
        idle();
        // 6: extreme values pass through bit-exact
        frame(0, 1'b0, 1'b1, 0, 8);
        idle();
        for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d pairs outstanding, want 0", q.size());
        end
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
